window_sr: RTL and testbench
============================

# window_sr

Parametrised parallel-out shift register for sliding-window feature extraction in the convolution datapath. It shifts WIDTH-bit samples through DEPTH stages and exposes all stages in parallel. It tracks fill level and asserts a stride-gated strobe telling the downstream multiply-accumulate array when a new window is ready. It is the generalised replacement for the fixed 8-bit parallel-out shift register.

## Interface
- WIDTH, 8, sample width in bits (≥1)
- DEPTH, 3, number of stages / window length (≥2)
- STRIDE, 1, shifts between window strobes once full (1..DEPTH)
- CW, $clog2(DEPTH+1), width of fill_count (derived, not overridden)
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- shift_en  in  1  advance the register by one sample this cycle
- shift_in  in  WIDTH  sample entering stage 0
- clear  in  1  synchronous flush
- load_en  in  1  parallel load (only with WINDOW_SR_PLOAD_EN)
- load_data  in  DEPTH*WIDTH  parallel load image, same packing as p_out (only with WINDOW_SR_PLOAD_EN)
- shift_out  out  WIDTH  oldest stage (stage DEPTH-1)
- p_out  out  DEPTH*WIDTH  all stages; stage DEPTH-1 (oldest) in the top slice, stage 0 (newest) in bits WIDTH-1:0
- fill_count  out  CW  valid samples held, saturates at DEPTH
- window_valid  out  1  fill_count == DEPTH
- window_strobe  out  1  one-cycle pulse: new window for consumer

## Operation
- Priority per edge: clear > load_en > shift_en > hold.
- Shift: stage[0] <= shift_in, stage[i] <= stage[i-1]; the oldest sample is discarded. fill_count <= min(fill_count+1, DEPTH).
- Stride phase counter sc (0..STRIDE-1, internal):
  - shift that makes fill reach DEPTH from DEPTH-1: sc <= 0, strobe fires.
  - shift while already full: sc <= (sc+1) mod STRIDE; strobe fires when the new sc == 0.
  - shift while not full and not reaching DEPTH: no strobe.
- Clear: all stages <= 0, fill_count <= 0, sc <= 0, window_strobe <= 0. shift_en in the same cycle is ignored.
- Load: stages <= load_data, fill_count <= DEPTH, sc <= 0, strobe fires.
- Hold (no shift_en): stages, fill_count and sc unchanged; window_strobe <= 0.
- shift_out and window_valid are combinational decodes of the registered state. All other outputs are registers.

## Timing
- Reset (async assert, sync release by the system): stages 0, p_out 0, shift_out 0, fill_count 0, window_valid 0, window_strobe 0, sc 0.
- Latency: a sample presented with shift_en at edge N appears in p_out[WIDTH-1:0] after edge N. It reaches shift_out after edge N+DEPTH-1, given continuous shifting.
- window_strobe is high for exactly the one cycle following the qualifying edge. Back-to-back strobes occur when STRIDE=1 and shift_en is held high.
- Reset asserted mid-fill or mid-stride returns all state to reset values immediately. The stride phase restarts from the first full window.
- shift_en gaps stall the fill and the stride phase; no state decays.

## Configuration
- WINDOW_SR_PLOAD_EN defined: load_en and load_data ports exist, with load behaviour as above.
- Undefined: both ports are absent, no load mux is built, and the priority becomes clear > shift_en > hold.

## Structure
- Shared package/header window_sr_pkg: default WIDTH/DEPTH/STRIDE constants, clog2 function, and the stage-slice index macro used by p_out consumers.
- One sub-module: window_sr_stride_ctrl, which owns fill_count, sc, window_valid and window_strobe. It takes shift/clear/load qualifiers only. The top level holds the data stages.

## Test plan
- DEPTH=3, WIDTH=8, STRIDE=1: reset, then counter 0,1,2,… with shift_en=1. Required: after the third edge, p_out=24'h000102, shift_out=8'h00, fill_count=3, window_valid=1, and strobe high that cycle and every cycle after.
- STRIDE=2, DEPTH=3, continuous shifting. Required: strobe on the 3rd, 5th and 7th shift edges only; fill_count stays at 3.
- shift_en toggled 1,0,1,0 with counter input. Required: p_out changes only after enabled edges; strobe never high in a cycle after a hold edge.
- Full window, then clear together with shift_en. Required: next cycle p_out=0, fill_count=0, window_valid=0, no strobe; refilling takes 3 shifts again.
- WINDOW_SR_PLOAD_EN, load_data=24'hAABBCC, then one shift of 8'h11. Required: p_out=24'hAABBCC with strobe, then 24'hBBCC11 with strobe (STRIDE=1).
- Reset asserted asynchronously mid-fill (fill_count=2, between edges). Required: all outputs 0 immediately; after release, the first strobe comes only after 3 further shifts.

Source files
------------

// File: rtl/window_sr_pkg.sv
// Shared defaults, constant clog2 and the p_out stage-slice macro for window_sr and its consumers.
`ifndef WINDOW_SR_PKG_SV
`define WINDOW_SR_PKG_SV

// Part-select for stage idx of a packed window of w-bit samples: bus[`WINDOW_SR_SLICE(idx, w)]
`define WINDOW_SR_SLICE(idx, w) ((idx)*(w)) +: (w)

package window_sr_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 3;
  localparam int DEF_STRIDE = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

`endif

// File: rtl/window_sr_stride_ctrl.sv
// Fill level and stride-phase tracking; strobe registered one cycle after the qualifying edge.
// Latency 1 cycle; no backpressure, idle cycles simply hold the phase.
module window_sr_stride_ctrl
  import window_sr_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int STRIDE = DEF_STRIDE,
  localparam int CW    = clog2(DEPTH + 1),
  localparam int SCW   = (STRIDE > 1) ? clog2(STRIDE) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          shift,
  input  logic          clear,
  input  logic          load,
  output logic [CW-1:0] fill_count,
  output logic          window_valid,
  output logic          window_strobe
);

  logic [SCW-1:0] sc;
  logic [SCW-1:0] sc_next;
  logic [SCW-1:0] sc_wrap;
  logic [CW-1:0]  fill_next;
  logic           strobe_next;
  logic           full;

  assign full         = (fill_count == CW'(DEPTH));
  assign window_valid = full;
  assign sc_wrap      = (sc == SCW'(STRIDE - 1)) ? '0 : sc + 1'b1;

  always_comb begin
    fill_next   = fill_count;
    sc_next     = sc;
    strobe_next = 1'b0;
    if (clear) begin
      fill_next = '0;
      sc_next   = '0;
    end else if (load) begin
      fill_next   = CW'(DEPTH);
      sc_next     = '0;
      strobe_next = 1'b1;
    end else if (shift) begin
      if (full) begin
        // Once full, every STRIDE-th shift completes a fresh window
        sc_next     = sc_wrap;
        strobe_next = (sc_wrap == '0);
      end else begin
        fill_next = fill_count + 1'b1;
        if (fill_count == CW'(DEPTH - 1)) begin
          sc_next     = '0;
          strobe_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_count    <= '0;
      sc            <= '0;
      window_strobe <= 1'b0;
    end else begin
      fill_count    <= fill_next;
      sc            <= sc_next;
      window_strobe <= strobe_next;
    end
  end

endmodule

// File: rtl/window_sr.sv
// Parallel-out sliding-window shift register; sample visible in p_out one cycle after shift_en.
// Optional parallel load built only with WINDOW_SR_PLOAD_EN; no backpressure, shift_en gaps stall.
module window_sr
  import window_sr_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int STRIDE = DEF_STRIDE,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       shift_in,
  input  logic                   clear,
`ifdef WINDOW_SR_PLOAD_EN
  input  logic                   load_en,
  input  logic [DEPTH*WIDTH-1:0] load_data,
`endif
  output logic [WIDTH-1:0]       shift_out,
  output logic [DEPTH*WIDTH-1:0] p_out,
  output logic [CW-1:0]          fill_count,
  output logic                   window_valid,
  output logic                   window_strobe
);

  logic load;

`ifdef WINDOW_SR_PLOAD_EN
  assign load = load_en;
`else
  assign load = 1'b0;
`endif

  assign shift_out = p_out[`WINDOW_SR_SLICE(DEPTH - 1, WIDTH)];

  // Stage 0 lives in the low slice, so a left shift ages every stage by one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_out <= '0;
    end else if (clear) begin
      p_out <= '0;
`ifdef WINDOW_SR_PLOAD_EN
    end else if (load_en) begin
      p_out <= load_data;
`endif
    end else if (shift_en) begin
      p_out <= {p_out[(DEPTH-1)*WIDTH-1:0], shift_in};
    end
  end

  window_sr_stride_ctrl #(
    .DEPTH  (DEPTH),
    .STRIDE (STRIDE)
  ) u_stride_ctrl (
    .clock         (clock),
    .reset         (reset),
    .shift         (shift_en),
    .clear         (clear),
    .load          (load),
    .fill_count    (fill_count),
    .window_valid  (window_valid),
    .window_strobe (window_strobe)
  );

endmodule

// File: tb/tb_window_sr.sv
// Scoreboarded bench: two window_sr instances (STRIDE 1 and 2) share one directed stimulus stream.
module tb_window_sr;

  localparam int W = 8;
  localparam int D = 3;

  typedef struct {
    logic [D*W-1:0] p;
    logic [1:0]     fill;
    logic           s1;
    logic           s2;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           shift_en = 1'b0;
  logic [W-1:0]   shift_in = '0;
  logic           clear = 1'b0;
  logic           load_en = 1'b0;
  logic [D*W-1:0] load_data = '0;

  logic [W-1:0]   so1, so2;
  logic [D*W-1:0] po1, po2;
  logic [1:0]     fc1, fc2;
  logic           wv1, wv2, st1, st2;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  window_sr #(.WIDTH(W), .DEPTH(D), .STRIDE(1)) u_s1 (
    .clock (clock), .reset (reset), .shift_en (shift_en), .shift_in (shift_in), .clear (clear),
`ifdef WINDOW_SR_PLOAD_EN
    .load_en (load_en), .load_data (load_data),
`endif
    .shift_out (so1), .p_out (po1), .fill_count (fc1), .window_valid (wv1), .window_strobe (st1)
  );

  window_sr #(.WIDTH(W), .DEPTH(D), .STRIDE(2)) u_s2 (
    .clock (clock), .reset (reset), .shift_en (shift_en), .shift_in (shift_in), .clear (clear),
`ifdef WINDOW_SR_PLOAD_EN
    .load_en (load_en), .load_data (load_data),
`endif
    .shift_out (so2), .p_out (po2), .fill_count (fc2), .window_valid (wv2), .window_strobe (st2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " p_out1"}, 32'(po1), 0);
    chk({tag, " shift_out1"}, 32'(so1), 0);
    chk({tag, " fill1"}, 32'(fc1), 0);
    chk({tag, " valid1"}, 32'(wv1), 0);
    chk({tag, " strobe1"}, 32'(st1), 0);
    chk({tag, " p_out2"}, 32'(po2), 0);
    chk({tag, " fill2"}, 32'(fc2), 0);
    chk({tag, " strobe2"}, 32'(st2), 0);
  endtask

  // Drive one edge's worth of inputs and queue what both instances must show after it
  task automatic step(input logic en, input logic [W-1:0] din, input logic clr,
                      input logic ld, input logic [D*W-1:0] ldat,
                      input logic [D*W-1:0] ep, input logic [1:0] ef,
                      input logic es1, input logic es2);
    exp_t e;
    @(negedge clock);
    shift_en  = en;
    shift_in  = din;
    clear     = clr;
    load_en   = ld;
    load_data = ldat;
    e.p = ep; e.fill = ef; e.s1 = es1; e.s2 = es2;
    sb.push_back(e);
  endtask

  task automatic sh(input logic [W-1:0] din, input logic [D*W-1:0] ep, input logic [1:0] ef,
                    input logic es1, input logic es2);
    step(1'b1, din, 1'b0, 1'b0, '0, ep, ef, es1, es2);
  endtask

  task automatic hold(input logic [D*W-1:0] ep, input logic [1:0] ef);
    step(1'b0, 8'h00, 1'b0, 1'b0, '0, ep, ef, 1'b0, 1'b0);
  endtask

  task automatic idle();
    @(negedge clock);
    shift_en = 1'b0;
    clear    = 1'b0;
    load_en  = 1'b0;
  endtask

  // Monitor: one queued expectation per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("p_out1", 32'(po1), 32'(e.p));
        chk("p_out2", 32'(po2), 32'(e.p));
        chk("shift_out1", 32'(so1), 32'(e.p[D*W-1 -: W]));
        chk("fill1", 32'(fc1), 32'(e.fill));
        chk("fill2", 32'(fc2), 32'(e.fill));
        chk("valid1", 32'(wv1), 32'(e.fill == 2'd3));
        chk("valid2", 32'(wv2), 32'(e.fill == 2'd3));
        chk("strobe1", 32'(st1), 32'(e.s1));
        chk("strobe2", 32'(st2), 32'(e.s2));
      end
    end
  end

  initial begin
    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Continuous fill with counter input; STRIDE=2 strobes on shifts 3, 5, 7
    sh(8'h00, 24'h000000, 2'd1, 0, 0);
    sh(8'h01, 24'h000001, 2'd2, 0, 0);
    sh(8'h02, 24'h000102, 2'd3, 1, 1);
    sh(8'h03, 24'h010203, 2'd3, 1, 0);
    sh(8'h04, 24'h020304, 2'd3, 1, 1);
    sh(8'h05, 24'h030405, 2'd3, 1, 0);
    sh(8'h06, 24'h040506, 2'd3, 1, 1);

    // Enable toggling: holds freeze data and phase and never strobe
    sh(8'h07, 24'h050607, 2'd3, 1, 0);
    hold(24'h050607, 2'd3);
    sh(8'h08, 24'h060708, 2'd3, 1, 1);
    hold(24'h060708, 2'd3);

    // Clear wins over a simultaneous shift, then refill takes three shifts
    step(1'b1, 8'h09, 1'b1, 1'b0, '0, 24'h000000, 2'd0, 0, 0);
    sh(8'h0A, 24'h00000A, 2'd1, 0, 0);
    sh(8'h0B, 24'h000A0B, 2'd2, 0, 0);
    sh(8'h0C, 24'h0A0B0C, 2'd3, 1, 1);
    sh(8'h0D, 24'h0B0C0D, 2'd3, 1, 0);

    // Async reset mid-fill, between edges
    step(1'b0, 8'h00, 1'b1, 1'b0, '0, 24'h000000, 2'd0, 0, 0);
    sh(8'h21, 24'h000021, 2'd1, 0, 0);
    sh(8'h22, 24'h002122, 2'd2, 0, 0);
    idle();
    @(posedge clock);
    #3 reset = 1'b0;
    #1 chk_all_zero("midfill reset");
    @(negedge clock);
    reset = 1'b1;
    sh(8'h31, 24'h000031, 2'd1, 0, 0);
    sh(8'h32, 24'h003132, 2'd2, 0, 0);
    sh(8'h33, 24'h313233, 2'd3, 1, 1);
    sh(8'h34, 24'h323334, 2'd3, 1, 0);

`ifdef WINDOW_SR_PLOAD_EN
    // Parallel load restarts the phase and strobes immediately
    step(1'b0, 8'h00, 1'b0, 1'b1, 24'hAABBCC, 24'hAABBCC, 2'd3, 1, 1);
    sh(8'h11, 24'hBBCC11, 2'd3, 1, 0);
`endif

    idle();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
